// File: rtl/mfe_sched_pkg.sv
// Shared types and width helpers for the mfe round-robin scheduler.
package mfe_sched_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_DW      = 32;
    localparam int DEF_RW      = 32;
    localparam int DEF_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must hold 0..t; a disabled watchdog still gets one bit.
    function automatic int wdog_width(input int t);
        return (t <= 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/mfe_sched_rr_arb.sv
// Combinational round-robin pick: first asserted request after the last winner.
module rr_arb
    import mfe_sched_pkg::*;
#(
    parameter int N  = DEF_N_REQ,
    parameter int IW = id_width(DEF_N_REQ)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // Scan last+1 .. last+N modulo N and take the first hit.
    always_comb begin
        int k;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        k     = 0;
        for (int off = 1; off <= N; off++) begin
            k = (int'(i_last) + off) % N;
            if (!o_any && i_req[k]) begin
                o_any    = 1'b1;
                o_gnt[k] = 1'b1;
                o_idx    = IW'(k);
            end else begin
                o_any = o_any;
            end
        end
    end

endmodule

// File: rtl/mfe_sched.sv
// Shares one mfe engine among N_REQ requesters: round-robin accept, start pulse,
// wait for done or watchdog timeout, then a tagged one-cycle response.
module mfe_sched
    import mfe_sched_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int DW      = DEF_DW,
    parameter int RW      = DEF_RW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [N_REQ-1:0]               req_valid,
    input  logic [N_REQ*DW-1:0]            req_data,
    output logic [N_REQ-1:0]               req_ready,
    output logic                           rsp_valid,
    output logic [id_width(N_REQ)-1:0]     rsp_id,
    output logic [RW-1:0]                  rsp_data,
    output logic                           rsp_err,
    output logic                           eng_start,
    output logic [DW-1:0]                  eng_data,
    input  logic                           eng_done,
    input  logic [RW-1:0]                  eng_result,
    output logic                           busy
);

    localparam int             IW      = id_width(N_REQ);
    localparam int             WDW     = wdog_width(TIMEOUT);
    localparam bit             WD_ON   = (TIMEOUT != 0);
    localparam logic [WDW-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WDW'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_last;
    logic [WDW-1:0]  r_wdog;
    logic [N_REQ-1:0] w_gnt;
    logic [IW-1:0]   w_idx;
    logic            w_any;
    logic            w_accept;
    logic            w_tmo;
    logic [DW-1:0]   w_sel;

    rr_arb #(
        .N  (N_REQ),
        .IW (IW)
    ) u_arb (
        .i_req  (req_valid),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    // Accept qualifier; gated by rst_n so no grant is visible while held in reset.
    always_comb begin
        w_accept = rst_n && en && w_any && (r_state == ST_IDLE);
        w_tmo    = WD_ON && (r_state == ST_WAIT) && (r_wdog == WD_LAST);
    end

    // Operand mux for the winning requester.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_idx == IW'(i)) begin
                w_sel = req_data[i*DW +: DW];
            end else begin
                w_sel = w_sel;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; in WAIT, done and timeout both lead to RESP.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = w_accept ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT:  w_next = (eng_done || w_tmo) ? ST_RESP : ST_WAIT;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Decoded outputs.
    always_comb begin
        req_ready = w_accept ? w_gnt : '0;
        eng_start = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            ST_IDLE:  busy      = 1'b0;
            ST_ISSUE: eng_start = 1'b1;
            ST_WAIT:  busy      = 1'b1;
            ST_RESP:  rsp_valid = 1'b1;
            default:  busy      = 1'b0;
        endcase
    end

    // Job datapath: operand/id latch, rr pointer, watchdog and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last   <= IW'(N_REQ - 1);
            r_wdog   <= '0;
            eng_data <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        eng_data <= w_sel;
                        rsp_id   <= w_idx;
                        r_last   <= w_idx;
                    end else begin
                        r_last <= r_last;
                    end
                end
                ST_ISSUE: r_wdog <= '0;
                ST_WAIT: begin
                    if (r_wdog != '1) begin
                        r_wdog <= r_wdog + WDW'(1);
                    end else begin
                        r_wdog <= r_wdog;
                    end
                    if (eng_done) begin
                        rsp_data <= eng_result;
                        rsp_err  <= 1'b0;
                    end else if (w_tmo) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end else begin
                        rsp_err <= rsp_err;
                    end
                end
                ST_RESP: r_wdog <= r_wdog;
                default: r_wdog <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mfe_sched.sv
// Directed bench for mfe_sched with N_REQ=4, TIMEOUT=16.
module tb_mfe_sched;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int RW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [RW-1:0]   rsp_data;
    logic            rsp_err;
    logic            eng_start;
    logic [DW-1:0]   eng_data;
    logic            eng_done = 1'b0;
    logic [RW-1:0]   eng_result = '0;
    logic            busy;

    int tests = 0;
    int fails = 0;
    int n;
    int w;
    logic [3:0] expg;

    mfe_sched #(.N_REQ(N), .DW(DW), .RW(RW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .eng_start  (eng_start),
        .eng_data   (eng_data),
        .eng_done   (eng_done),
        .eng_result (eng_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_start", eng_start, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_eng_data", eng_data, 32'h0);
        cyc;
        rst_n = 1'b1;

        // Round robin with all requesters valid, done on second WAIT cycle
        en        = 1'b1;
        req_data  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        req_valid = 4'b1111;
        for (int j = 0; j < 6; j++) begin
            w    = j % 4;
            expg = 4'b0001 << w;
            #1;
            chk("rr_ready", req_ready, expg);
            cyc;
            #1;
            chk("rr_start", eng_start, 1'b1);
            chk("rr_eng_data", eng_data, 32'hD0 + w);
            cyc;
            chk("rr_wait1_norsp", rsp_valid, 1'b0);
            cyc;
            eng_done   = 1'b1;
            eng_result = 32'h100 + j;
            cyc;
            eng_done = 1'b0;
            #1;
            chk("rr_rsp_valid", rsp_valid, 1'b1);
            chk("rr_rsp_id", rsp_id, w[1:0]);
            chk("rr_rsp_data", rsp_data, 32'h100 + j);
            chk("rr_rsp_err", rsp_err, 1'b0);
            cyc;
        end
        req_valid = 4'b0000;
        #1;
        chk("rr_idle", busy, 1'b0);

        // Single job from requester 0, done on fifth WAIT cycle
        req_data  = {32'hD3, 32'hD2, 32'hD1, 32'h11};
        req_valid = 4'b0001;
        #1;
        chk("sj_ready", req_ready, 4'b0001);
        cyc;
        req_valid = 4'b0000;
        #1;
        chk("sj_start", eng_start, 1'b1);
        chk("sj_eng_data", eng_data, 32'h11);
        chk("sj_ready_off", req_ready, 4'b0000);
        cyc;
        chk("sj_start_once", eng_start, 1'b0);
        chk("sj_busy", busy, 1'b1);
        cyc; cyc; cyc; cyc;
        eng_done   = 1'b1;
        eng_result = 32'hAB;
        cyc;
        eng_done = 1'b0;
        #1;
        chk("sj_rsp_valid", rsp_valid, 1'b1);
        chk("sj_rsp_id", rsp_id, 2'd0);
        chk("sj_rsp_data", rsp_data, 32'hAB);
        chk("sj_rsp_err", rsp_err, 1'b0);
        cyc;
        chk("sj_rsp_pulse", rsp_valid, 1'b0);
        chk("sj_idle", busy, 1'b0);

        // Watchdog timeout on requester 2; stray done during ISSUE
        req_valid = 4'b0100;
        #1;
        chk("to_ready", req_ready, 4'b0100);
        cyc;
        req_valid = 4'b0000;
        eng_done  = 1'b1;
        #1;
        chk("to_start", eng_start, 1'b1);
        cyc;
        eng_done = 1'b0;
        #1;
        chk("to_issue_done_ignored", rsp_valid, 1'b0);
        chk("to_wait_busy", busy, 1'b1);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            cyc;
            n++;
        end
        chk("to_cycles", n, 16);
        chk("to_rsp_err", rsp_err, 1'b1);
        chk("to_rsp_data", rsp_data, 32'h0);
        chk("to_rsp_id", rsp_id, 2'd2);
        cyc;

        // Next request accepted normally, minimum 3-cycle latency
        req_data  = {32'hD3, 32'hD2, 32'hD1, 32'h22};
        req_valid = 4'b0001;
        #1;
        chk("nx_ready", req_ready, 4'b0001);
        cyc;
        req_valid = 4'b0000;
        cyc;
        eng_done   = 1'b1;
        eng_result = 32'h33;
        cyc;
        eng_done = 1'b0;
        #1;
        chk("nx_rsp_valid", rsp_valid, 1'b1);
        chk("nx_rsp_data", rsp_data, 32'h33);
        chk("nx_rsp_err", rsp_err, 1'b0);
        cyc;

        // Stray eng_done while IDLE
        eng_done = 1'b1;
        cyc;
        chk("stray_idle_rsp", rsp_valid, 1'b0);
        chk("stray_idle_busy", busy, 1'b0);
        cyc;
        chk("stray_idle_rsp2", rsp_valid, 1'b0);
        eng_done = 1'b0;

        // Done coincident with the timeout cycle: done wins
        req_valid = 4'b0001;
        #1;
        chk("co_ready", req_ready, 4'b0001);
        cyc;
        req_valid = 4'b0000;
        cyc;
        for (int k = 2; k <= TO; k++) begin
            cyc;
        end
        chk("co_no_early_rsp", rsp_valid, 1'b0);
        eng_done   = 1'b1;
        eng_result = 32'h5A;
        cyc;
        eng_done = 1'b0;
        #1;
        chk("co_rsp_valid", rsp_valid, 1'b1);
        chk("co_rsp_err", rsp_err, 1'b0);
        chk("co_rsp_data", rsp_data, 32'h5A);
        cyc;

        // en gating, then en drop mid-job
        en        = 1'b0;
        req_valid = 4'b1010;
        #1;
        chk("en_block", req_ready, 4'b0000);
        cyc;
        chk("en_block2", req_ready, 4'b0000);
        chk("en_block_busy", busy, 1'b0);
        en = 1'b1;
        #1;
        chk("en_grant1", req_ready, 4'b0010);
        cyc;
        req_valid = 4'b0000;
        en        = 1'b0;
        cyc;
        cyc;
        eng_done   = 1'b1;
        eng_result = 32'h77;
        cyc;
        eng_done = 1'b0;
        #1;
        chk("en_rsp_valid", rsp_valid, 1'b1);
        chk("en_rsp_id", rsp_id, 2'd1);
        chk("en_rsp_data", rsp_data, 32'h77);
        cyc;
        chk("en_idle", busy, 1'b0);

        // Asynchronous reset mid-WAIT
        en        = 1'b1;
        req_data  = {32'hC3, 32'hD2, 32'hD1, 32'hC0};
        req_valid = 4'b1000;
        #1;
        chk("rs_ready", req_ready, 4'b1000);
        cyc;
        req_valid = 4'b0000;
        cyc;
        cyc;
        #2;
        req_valid = 4'b1001;
        rst_n     = 1'b0;
        #1;
        chk("rs_busy", busy, 1'b0);
        chk("rs_start", eng_start, 1'b0);
        chk("rs_eng_data", eng_data, 32'h0);
        chk("rs_rsp_valid", rsp_valid, 1'b0);
        chk("rs_rsp_id", rsp_id, 2'd0);
        chk("rs_rsp_data", rsp_data, 32'h0);
        chk("rs_rsp_err", rsp_err, 1'b0);
        chk("rs_ready_off", req_ready, 4'b0000);
        cyc;
        chk("rs_hold_norsp", rsp_valid, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rs_prio0", req_ready, 4'b0001);
        cyc;
        req_valid = 4'b0000;
        #1;
        chk("rs_start_after", eng_start, 1'b1);
        chk("rs_eng_data_after", eng_data, 32'hC0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mfe_sched.md
Name: mfe_sched

Overview:
- Round-robin scheduler that shares one mfe engine among N_REQ requesters.
- Accepts one job at a time, pulses the engine start, waits for engine done or a watchdog timeout, then returns the result tagged with requester id.
- Sits between requester ports and the mfe datapath; lets multiple bench/system agents drive a single mfe instance.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- DW, 32, job operand width to engine
- RW, 32, engine result width
- TIMEOUT, 1024, max cycles in WAIT before abort; 0 disables watchdog

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  accept enable; 0 blocks new accepts, in-flight job completes
- req_valid  in  N_REQ  per-requester job valid
- req_data  in  N_REQ*DW  job operands, requester i at bits [i*DW +: DW]
- req_ready  out  N_REQ  one-hot accept pulse
- rsp_valid  out  1  response pulse, one cycle
- rsp_id  out  $clog2(N_REQ)  requester index of response
- rsp_data  out  RW  engine result; 0 on error
- rsp_err  out  1  timeout abort flag, valid with rsp_valid
- eng_start  out  1  one-cycle start pulse to engine
- eng_data  out  DW  operands to engine, held stable from start until response
- eng_done  in  1  engine completion pulse
- eng_result  in  RW  engine result, valid with eng_done
- busy  out  1  high in any state except IDLE

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset (async, any state): state IDLE; rr pointer last = N_REQ-1, so requester 0 has first priority. All outputs 0: req_ready, rsp_*, eng_start, eng_data, busy. Watchdog counter 0.
- IDLE: if en && |req_valid, winner = first set bit searching last+1, last+2, … modulo N_REQ.
  - req_ready[winner]=1 combinationally that cycle.
  - Latch req_data slice into eng_data and id into rsp_id; last <= winner; go ISSUE.
  - Otherwise stay; req_ready=0.
- ISSUE: eng_start=1 for exactly this cycle; clear watchdog; go WAIT. eng_done here is ignored.
- WAIT: watchdog increments each cycle.
  - eng_done=1: capture eng_result into rsp_data, rsp_err=0, go RESP.
  - Else if TIMEOUT!=0 and watchdog==TIMEOUT-1: rsp_data=0, rsp_err=1, go RESP.
  - Done and timeout in the same cycle: done wins.
- RESP: rsp_valid=1 for one cycle with rsp_id/rsp_data/rsp_err; go IDLE.
- Timing: next accept is possible in the cycle after RESP. Minimum accept-to-rsp_valid latency is 3 cycles, with done in the first WAIT cycle.
- eng_done outside WAIT is ignored; no state change.
- Requester contract: hold req_valid and data until req_ready. Deasserting earlier is legal; the request is simply not counted.
- Fairness: the most recent winner has lowest priority next round. With all requesters permanently valid, grants cycle 0,1,2,3,0…
- en deassert mid-job does not abort; it only blocks the next accept.
- Watchdog width: $clog2(TIMEOUT+1), saturating. No arithmetic overflow is possible.
- Reset mid-job: drop job, no rsp_valid, engine not signalled (engine reset is separate).

Decomposition:
- Package mfe_sched_pkg: state enum (IDLE, ISSUE, WAIT, RESP), default widths, N_REQ id width helper.
- Sub-module rr_arb: N-way round-robin pick with inputs req and last, outputs one-hot gnt and index. Purely combinational; pointer register stays in mfe_sched.

Test Plan:
- Single job: req_valid=4'b0001, data 0x11; engine done after 5 cycles with 0xAB → req_ready[0] pulse, eng_start one cycle later with eng_data=0x11, rsp_valid with id 0, data 0xAB, err 0.
- All four requesters valid continuously, engine done in 2 cycles → grant order 0,1,2,3,0,1; each rsp_id matches that order; no requester starved.
- Engine never asserts done, TIMEOUT=16 → rsp_valid exactly 16 cycles after the first WAIT cycle, err=1, data=0; next request then accepted normally.
- eng_done coincident with timeout cycle → err=0, data=eng_result. Stray eng_done in IDLE/ISSUE → no rsp_valid.
- en=0 with req_valid=4'b1010 → no req_ready. Raise en → requester 1 granted. Drop en during WAIT → job still completes.
- Assert rst_n=0 asynchronously mid-WAIT → all outputs 0 immediately. After release, requester 0 wins over 3 when both valid.
